// File: rtl/lock_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lock_pkg : state encoding and default constants for the lock controller
// Rev 1.0
// ----------------------------------------------------------------------------
package lock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_CHECK   = 3'd2,
      ST_OPEN    = 3'd3,
      ST_LOCKOUT = 3'd4
   } lock_state_t;

   localparam int         c_DEF_CODE_LEN    = 4;
   localparam logic [3:0] c_DEF_RESET_CODE  = 4'b0100;
   localparam int         c_DEF_MAX_FAILS   = 3;
   localparam int         c_DEF_OPEN_CYC    = 8;
   localparam int         c_DEF_LOCKOUT_CYC = 16;
   localparam int         c_DEF_ENTRY_TO    = 10;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lock_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lock_if : code entry, programming and status signals of the lock controller
// Rev 1.0
// ----------------------------------------------------------------------------
interface lock_if #(
   parameter int CODE_LEN = lock_pkg::c_DEF_CODE_LEN
);
   logic                code;
   logic                bit_valid;
   logic                prog_load;
   logic [CODE_LEN-1:0] new_code;
   logic                openlock;
   logic                alarm;
   logic                busy;
   logic [1:0]          fail_cnt;

   modport master (
      output code, bit_valid, prog_load, new_code,
      input  openlock, alarm, busy, fail_cnt
   );

   modport slave (
      input  code, bit_valid, prog_load, new_code,
      output openlock, alarm, busy, fail_cnt
   );
endinterface
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lock_timer : loadable down-counter, done while the count is zero
// Rev 1.0
// ----------------------------------------------------------------------------
module lock_timer #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);
   logic [WIDTH-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (load) begin
         r_cnt <= load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - WIDTH'(1);
      end
   end

   assign done = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/lock_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lock_controller : serial code lock with failure counting, lockout and
//                   reprogramming of the stored code while open
// Rev 1.0
// ----------------------------------------------------------------------------
module lock_controller
   import lock_pkg::*;
#(
   parameter int                  CODE_LEN    = c_DEF_CODE_LEN,
   parameter logic [CODE_LEN-1:0] RESET_CODE  = c_DEF_RESET_CODE,
   parameter int                  MAX_FAILS   = c_DEF_MAX_FAILS,
   parameter int                  OPEN_CYC    = c_DEF_OPEN_CYC,
   parameter int                  LOCKOUT_CYC = c_DEF_LOCKOUT_CYC,
   parameter int                  ENTRY_TO    = c_DEF_ENTRY_TO
) (
   input  logic clk,
   input  logic reset,
   lock_if.slave bus
);
   localparam int c_TMR_W = $clog2(max3(OPEN_CYC, LOCKOUT_CYC, ENTRY_TO) + 1);
   localparam int c_CNT_W = $clog2(CODE_LEN + 1);

   lock_state_t         r_state, w_next;
   logic [CODE_LEN-1:0] r_entry, r_stored;
   logic [c_CNT_W-1:0]  r_bit_cnt;
   logic [1:0]          r_fail_cnt, w_fail_inc;
   logic                r_openlock, r_alarm, r_busy;
   logic                w_tmr_load, w_tmr_done;
   logic [c_TMR_W-1:0]  w_tmr_val;
   logic                w_accept, w_last_bit, w_timeout, w_match;

   assign w_accept   = bus.bit_valid && (r_state == ST_IDLE || r_state == ST_COLLECT);
   assign w_last_bit = (r_state == ST_COLLECT) && bus.bit_valid
                       && (r_bit_cnt == c_CNT_W'(CODE_LEN - 1));
   assign w_timeout  = (r_state == ST_COLLECT) && !bus.bit_valid && w_tmr_done;
   assign w_match    = (r_entry == r_stored);
   assign w_fail_inc = (r_fail_cnt == 2'(MAX_FAILS)) ? r_fail_cnt : r_fail_cnt + 2'd1;

   // One timer serves the entry timeout, the open window and the lockout window
   lock_timer #(.WIDTH(c_TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (w_tmr_load),
      .load_val (w_tmr_val),
      .done     (w_tmr_done)
   );

   always_comb begin
      w_next     = r_state;
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      case (r_state)
         ST_IDLE: begin
            if (bus.bit_valid) begin
               w_next     = ST_COLLECT;
               w_tmr_load = 1'b1;
               w_tmr_val  = c_TMR_W'(ENTRY_TO - 1);
            end
         end
         ST_COLLECT: begin
            if (bus.bit_valid) begin
               w_tmr_load = 1'b1;
               w_tmr_val  = c_TMR_W'(ENTRY_TO - 1);
               if (w_last_bit) w_next = ST_CHECK;
            end else if (w_tmr_done) begin
               w_next = ST_IDLE;
            end
         end
         ST_CHECK: begin
            w_tmr_load = 1'b1;
            if (w_match) begin
               w_next    = ST_OPEN;
               w_tmr_val = c_TMR_W'(OPEN_CYC - 1);
            end else if (w_fail_inc == 2'(MAX_FAILS)) begin
               w_next    = ST_LOCKOUT;
               w_tmr_val = c_TMR_W'(LOCKOUT_CYC - 1);
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_OPEN, ST_LOCKOUT: begin
            if (w_tmr_done) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_entry    <= '0;
         r_bit_cnt  <= '0;
         r_stored   <= RESET_CODE;
         r_fail_cnt <= '0;
         r_openlock <= 1'b0;
         r_alarm    <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next == ST_CHECK) || (w_next == ST_OPEN) || (w_next == ST_LOCKOUT);
         // openlock/alarm trail the state by one cycle so the lock opens two
         // cycles after the last bit is sampled
         r_openlock <= (r_state == ST_OPEN);
         r_alarm    <= (r_state == ST_LOCKOUT);
         if (w_accept) begin
            r_entry   <= {r_entry[CODE_LEN-2:0], bus.code};
            r_bit_cnt <= (r_state == ST_IDLE) ? c_CNT_W'(1) : r_bit_cnt + c_CNT_W'(1);
         end else if (w_timeout) begin
            r_entry   <= '0;
            r_bit_cnt <= '0;
         end
         if (r_state == ST_CHECK) begin
            r_bit_cnt  <= '0;
            r_fail_cnt <= w_match ? 2'd0 : w_fail_inc;
         end
         if (r_state == ST_LOCKOUT && w_tmr_done) r_fail_cnt <= '0;
         if (r_state == ST_OPEN && bus.prog_load) r_stored <= bus.new_code;
      end
   end

   assign bus.openlock = r_openlock;
   assign bus.alarm    = r_alarm;
   assign bus.busy     = r_busy;
   assign bus.fail_cnt = r_fail_cnt;
endmodule
`default_nettype wire

// File: tb/tb_lock_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lock_controller : directed scenarios plus random traffic against a
//                      window-based reference model of the lock
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_lock_controller;
   localparam int             CL       = 4;
   localparam int             MAXF     = 3;
   localparam int             OPEN_C   = 8;
   localparam int             LOCK_C   = 16;
   localparam int             ENTRY_T  = 10;
   localparam logic [CL-1:0]  RST_CODE = 4'b0100;

   logic clk = 1'b0;
   logic reset;

   lock_if #(.CODE_LEN(CL)) bus ();

   lock_controller #(
      .CODE_LEN    (CL),
      .RESET_CODE  (RST_CODE),
      .MAX_FAILS   (MAXF),
      .OPEN_CYC    (OPEN_C),
      .LOCKOUT_CYC (LOCK_C),
      .ENTRY_TO    (ENTRY_T)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_edge   = 0;

   // Reference model: entry bits as a queue, OPEN/LOCKOUT/CHECK as edge windows
   bit            m_q[$];
   logic [CL-1:0] m_stored = RST_CODE;
   logic [CL-1:0] m_entry  = '0;
   int            m_fails  = 0;
   int            m_last   = 0;
   int            m_check  = -1;
   int            m_olo = -1, m_ohi = -2, m_llo = -1, m_lhi = -2;
   logic          m_open = 1'b0, m_alarm = 1'b0, m_busy = 1'b0;

   int first, cnt, p;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", tag, n_edge, obs, exp);
      end
   endtask

   task automatic model_edge();
      bit in_chk, in_open, in_lock;
      if (reset) begin
         m_q.delete();
         m_stored = RST_CODE;
         m_fails  = 0;
         m_check  = -1;
         m_olo = -1; m_ohi = -2; m_llo = -1; m_lhi = -2;
         m_open = 1'b0; m_alarm = 1'b0; m_busy = 1'b0;
      end else begin
         in_chk  = (n_edge == m_check);
         in_open = (n_edge >= m_olo) && (n_edge <= m_ohi);
         in_lock = (n_edge >= m_llo) && (n_edge <= m_lhi);
         m_open  = in_open;
         m_alarm = in_lock;
         if (in_chk) begin
            if (m_entry == m_stored) begin
               m_fails = 0;
               m_olo = n_edge + 1;
               m_ohi = n_edge + OPEN_C;
            end else begin
               if (m_fails < MAXF) m_fails++;
               if (m_fails == MAXF) begin
                  m_llo = n_edge + 1;
                  m_lhi = n_edge + LOCK_C;
               end
            end
         end else if (in_open) begin
            if (bus.prog_load) m_stored = bus.new_code;
         end else if (in_lock) begin
            if (n_edge == m_lhi) m_fails = 0;
         end else if (bus.bit_valid) begin
            m_q.push_back(bus.code);
            m_last = n_edge;
            if (m_q.size() == CL) begin
               m_entry = '0;
               foreach (m_q[i]) m_entry = {m_entry[CL-2:0], m_q[i]};
               m_q.delete();
               m_check = n_edge + 1;
            end
         end else if (m_q.size() != 0 && (n_edge - m_last) == ENTRY_T) begin
            m_q.delete();
         end
         m_busy = (m_check == n_edge + 1)
                  || ((n_edge + 1 >= m_olo) && (n_edge + 1 <= m_ohi))
                  || ((n_edge + 1 >= m_llo) && (n_edge + 1 <= m_lhi));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      n_edge++;
      #1;
      chk_eq("openlock", 32'(bus.openlock), 32'(m_open));
      chk_eq("alarm",    32'(bus.alarm),    32'(m_alarm));
      chk_eq("busy",     32'(bus.busy),     32'(m_busy));
      chk_eq("fail_cnt", 32'(bus.fail_cnt), 32'(m_fails));
      chk_eq("exclusive", 32'(bus.openlock & bus.alarm), 32'd0);
   endtask

   task automatic idle(input int k);
      bus.bit_valid = 1'b0;
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic send_code(input logic [CL-1:0] v);
      for (int i = CL - 1; i >= 0; i--) begin
         bus.bit_valid = 1'b1;
         bus.code      = v[i];
         tick();
      end
      bus.bit_valid = 1'b0;
      bus.code      = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.code      = 1'b0;
      bus.bit_valid = 1'b0;
      bus.prog_load = 1'b0;
      bus.new_code  = '0;
      idle(2);
      reset = 1'b0;
      chk_eq("rst_busy", 32'(bus.busy), 32'd0);

      // Correct code: latency and open length
      send_code(4'b0100);
      first = -1; cnt = 0;
      for (int i = 1; i <= 14; i++) begin
         tick();
         if (bus.openlock) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
      chk_eq("s1_latency", 32'(first), 32'd2);
      chk_eq("s1_open_len", 32'(cnt), 32'd8);
      chk_eq("s1_fail", 32'(bus.fail_cnt), 32'd0);

      // Three wrong entries lead to lockout
      send_code(4'b1111); tick();
      chk_eq("s2_fail1", 32'(bus.fail_cnt), 32'd1);
      idle(2);
      send_code(4'b1111); tick();
      chk_eq("s2_fail2", 32'(bus.fail_cnt), 32'd2);
      idle(2);
      send_code(4'b1111);
      cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.alarm) cnt++;
      end
      chk_eq("s2_alarm_len", 32'(cnt), 32'd16);
      chk_eq("s2_fail_after", 32'(bus.fail_cnt), 32'd0);

      // Partial entry times out without touching fail_cnt
      send_code(4'b1111); tick();
      bus.bit_valid = 1'b1; bus.code = 1'b0; tick();
      bus.code = 1'b1; tick();
      idle(12);
      chk_eq("s3_fail_kept", 32'(bus.fail_cnt), 32'd1);
      send_code(4'b0100); idle(2);
      chk_eq("s3_open", 32'(bus.openlock), 32'd1);
      idle(10);

      // Reprogramming while open
      send_code(4'b0100); idle(3);
      bus.prog_load = 1'b1; bus.new_code = 4'b1010; tick();
      bus.prog_load = 1'b0;
      idle(8);
      send_code(4'b0100); tick();
      chk_eq("s4_old_fails", 32'(bus.fail_cnt), 32'd1);
      idle(2);
      send_code(4'b1010); idle(2);
      chk_eq("s4_new_opens", 32'(bus.openlock), 32'd1);
      // Load on the final OPEN edge is kept, the one right after is not
      idle(6);
      bus.prog_load = 1'b1; bus.new_code = 4'b0100; tick();
      bus.new_code = 4'b1111; tick();
      bus.prog_load = 1'b0;
      idle(2);
      send_code(4'b0100); idle(2);
      chk_eq("s4_last_load", 32'(bus.openlock), 32'd1);
      idle(10);

      // Reset mid-LOCKOUT and mid-COLLECT
      for (int k = 0; k < 3; k++) begin
         send_code(4'b1111); idle(2);
      end
      idle(4);
      reset = 1'b1; tick(); reset = 1'b0;
      chk_eq("s5_alarm", 32'(bus.alarm), 32'd0);
      chk_eq("s5_fail", 32'(bus.fail_cnt), 32'd0);
      bus.bit_valid = 1'b1; bus.code = 1'b1; tick(); tick();
      bus.bit_valid = 1'b0;
      reset = 1'b1; tick(); reset = 1'b0;
      chk_eq("s5_busy", 32'(bus.busy), 32'd0);
      send_code(4'b0100); idle(2);
      chk_eq("s5_open_after", 32'(bus.openlock), 32'd1);
      idle(10);

      // bit_valid pulses in CHECK, OPEN and LOCKOUT are dropped
      send_code(4'b0100);
      cnt = 0;
      for (int i = 1; i <= 14; i++) begin
         bus.bit_valid = (i == 1) || (i >= 3 && i <= 6);
         bus.code      = i[0];
         tick();
         if (bus.openlock) cnt++;
      end
      bus.bit_valid = 1'b0;
      chk_eq("s6_open_len", 32'(cnt), 32'd8);
      chk_eq("s6_open_fail", 32'(bus.fail_cnt), 32'd0);
      for (int k = 0; k < 2; k++) begin
         send_code(4'b1111); idle(2);
      end
      send_code(4'b1111);
      cnt = 0;
      for (int i = 1; i <= 20; i++) begin
         bus.bit_valid = (i >= 2) && (i <= 16) && (i[0] == 1'b0);
         bus.code      = 1'b1;
         tick();
         if (bus.alarm) cnt++;
      end
      bus.bit_valid = 1'b0;
      chk_eq("s6_alarm_len", 32'(cnt), 32'd16);
      chk_eq("s6_lock_fail", 32'(bus.fail_cnt), 32'd0);

      // Random traffic with varying bit density
      for (int blk = 0; blk < 30; blk++) begin
         case ($urandom_range(0, 2))
            0:       p = 90;
            1:       p = 50;
            default: p = 5;
         endcase
         for (int c = 0; c < 100; c++) begin
            reset         = ($urandom_range(0, 249) == 0);
            bus.bit_valid = ($urandom_range(0, 99) < p);
            bus.code      = 1'($urandom_range(0, 1));
            bus.prog_load = ($urandom_range(0, 5) == 0);
            bus.new_code  = CL'($urandom_range(0, 15));
            tick();
         end
      end
      reset = 1'b0;
      idle(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
